// File: rtl/poly_mem_pkg.sv
// Shared constants and state encoding for the polynomial RAM sequencer.
package poly_mem_pkg;
  localparam int DATA_W  = 26;
  localparam int ADDR_W  = 11;
  localparam int MAX_IDX = 756;

  typedef enum logic [1:0] {IDLE, LOAD, STREAM, DONE} state_t;
endpackage

// File: rtl/poly_mem_seq_out_stage.sv
// Single-entry registered valid/ready output stage with a last sideband.
module poly_out_stage
  import poly_mem_pkg::*;
#(
  parameter int W = DATA_W
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] push_data,
  input  logic         push_last,
  input  logic         ready,
  output logic         valid,
  output logic [W-1:0] data,
  output logic         last,
  output logic         load_en
);
  assign load_en = !valid || ready;

  // data only moves on a push so a stalled word stays put
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      last  <= 1'b0;
      data  <= '0;
    end else if (load_en) begin
      valid <= push;
      last  <= push && push_last;
      if (push) data <= push_data;
    end
  end
endmodule

// File: rtl/poly_mem_seq.sv
// Loads deg+1 coefficients into the RAM, then streams them back forward or reversed.
// state  | meaning
// IDLE   | waiting for start; rejects deg_in > MAX_IDX with err
// LOAD   | accepting coefficients, one RAM write per handshake
// STREAM | reading RAM into the output register, one word per cycle
// DONE   | one-cycle done pulse, then back to IDLE
module poly_mem_seq #(
  parameter int DATA_W  = poly_mem_pkg::DATA_W,
  parameter int ADDR_W  = poly_mem_pkg::ADDR_W,
  parameter int MAX_IDX = poly_mem_pkg::MAX_IDX
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] deg_in,
  input  logic              rev,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic              out_last,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_waddr,
  output logic [DATA_W-1:0] ram_wdata,
  output logic [ADDR_W-1:0] ram_raddr,
  input  logic [DATA_W-1:0] ram_rdata,
  output logic [ADDR_W-1:0] ram_deg
);
  import poly_mem_pkg::*;

  localparam logic [ADDR_W-1:0] MAX_A = ADDR_W'(MAX_IDX);

  state_t state, state_nxt;
  logic [ADDR_W-1:0] deg, wr_idx, rd_idx;
  logic rev_q, pending, err_q;
  logic accept, reject, push, load_en, final_elem;

  assign ram_we     = in_ready && in_valid;
  assign ram_waddr  = wr_idx;
  assign ram_wdata  = in_data;
  assign ram_raddr  = rd_idx;
  assign err        = err_q;
  assign final_elem = rev_q ? (rd_idx == '0) : (rd_idx == deg);

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    push      = 1'b0;
    accept    = 1'b0;
    reject    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (deg_in <= MAX_A) begin
            accept    = 1'b1;
            state_nxt = LOAD;
          end else begin
            reject = 1'b1;
          end
        end
      end
      LOAD: begin
        in_ready = 1'b1;
        busy     = 1'b1;
        if (in_valid && wr_idx == deg) state_nxt = STREAM;
      end
      STREAM: begin
        busy = 1'b1;
        push = pending && load_en;
        if (out_valid && out_ready && out_last) state_nxt = DONE;
      end
      DONE: begin
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // the final element clears pending instead of stepping, so rd_idx never wraps
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      deg     <= '0;
      rev_q   <= 1'b0;
      wr_idx  <= '0;
      rd_idx  <= '0;
      pending <= 1'b0;
      err_q   <= 1'b0;
      ram_deg <= '0;
    end else begin
      err_q <= reject;
      if (accept) begin
        deg     <= deg_in;
        rev_q   <= rev;
        ram_deg <= deg_in;
        wr_idx  <= '0;
      end
      if (ram_we) begin
        wr_idx <= wr_idx + 1'b1;
        if (wr_idx == deg) begin
          pending <= 1'b1;
          rd_idx  <= rev_q ? deg : '0;
        end
      end
      if (push) begin
        if (final_elem)  pending <= 1'b0;
        else if (rev_q)  rd_idx  <= rd_idx - 1'b1;
        else             rd_idx  <= rd_idx + 1'b1;
      end
    end
  end

  poly_out_stage #(.W(DATA_W)) u_out (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push),
    .push_data (ram_rdata),
    .push_last (final_elem),
    .ready     (out_ready),
    .valid     (out_valid),
    .data      (out_data),
    .last      (out_last),
    .load_en   (load_en)
  );
endmodule

// File: tb/tb_poly_mem_seq.sv
// Self-checking bench for poly_mem_seq: table of jobs, random jobs and hand-written corner sequences.
module tb_poly_mem_seq;
  localparam int DW = 26;
  localparam int AW = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n, start, rev, in_valid, in_ready, out_valid, out_ready, out_last;
  logic          busy, done, err, ram_we;
  logic [AW-1:0] deg_in, ram_waddr, ram_raddr, ram_deg;
  logic [DW-1:0] in_data, out_data, ram_wdata, ram_rdata;

  poly_mem_seq dut (
    .clk(clk), .rst_n(rst_n), .start(start), .deg_in(deg_in), .rev(rev),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .busy(busy), .done(done), .err(err),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_raddr(ram_raddr), .ram_rdata(ram_rdata), .ram_deg(ram_deg)
  );

  // distributed RAM: synchronous write, combinational read
  logic [DW-1:0] mem [0:2047];
  always @(posedge clk) if (ram_we) mem[ram_waddr] <= ram_wdata;
  assign ram_rdata = mem[ram_raddr];

  int errors = 0;
  int checks = 0;
  int last_deg = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_reset_vals();
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_last", int'(out_last), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_done", int'(done), 0);
    chk("rst_err", int'(err), 0);
    chk("rst_ram_we", int'(ram_we), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_ram_waddr", int'(ram_waddr), 0);
    chk("rst_ram_raddr", int'(ram_raddr), 0);
    chk("rst_ram_deg", int'(ram_deg), 0);
  endtask

  // rmode: 0 = out_ready always 1, 1 = random, 2 = repeating 1,0,0,1,1
  task automatic run_job(input int deg, input bit rv, input int dsel, input bit gaps,
                         input int rmode, input bit noise, input int exp_cycles, input int abort_at);
    logic [DW-1:0] src[$];
    logic [DW-1:0] expq[$];
    logic [DW-1:0] held;
    bit pat[5];
    int k, nhs, ncyc;
    bit seen_done, prev_last_hs, stalled;
    pat = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    for (int i = 0; i <= deg; i++) begin
      if (dsel == 0)      src.push_back(DW'(10 + i));
      else if (dsel == 1) src.push_back(DW'(i));
      else                src.push_back(DW'($urandom));
    end
    for (int i = 0; i <= deg; i++) expq.push_back(src[rv ? deg - i : i]);

    start = 1'b1; deg_in = AW'(deg); rev = rv; in_valid = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0; nhs = 0; ncyc = 0; seen_done = 0; prev_last_hs = 0; stalled = 0; held = '0;
    while (!seen_done && ncyc < 3 * deg + 60) begin
      in_valid  = (k <= deg) && (!gaps || ($urandom % 3 != 0));
      in_data   = (k <= deg) ? src[k] : '0;
      out_ready = (rmode == 0) ? 1'b1 : (rmode == 1) ? 1'($urandom % 2) : pat[ncyc % 5];
      if (noise) begin
        start  = 1'($urandom % 2);
        deg_in = AW'($urandom);
        rev    = 1'($urandom % 2);
      end
      @(negedge clk);
      if (ncyc == 0) begin
        chk("first_in_ready", int'(in_ready), 1);
        chk("first_busy", int'(busy), 1);
        chk("ram_deg_latched", int'(ram_deg), deg);
      end
      chk("err_quiet", int'(err), 0);
      chk("in_ready", int'(in_ready), int'(k <= deg));
      chk("ram_we", int'(ram_we), int'(in_valid && k <= deg));
      if (in_valid && k <= deg) begin
        chk("ram_waddr", int'(ram_waddr), k);
        chk("ram_wdata", int'(ram_wdata), int'(src[k]));
        k++;
      end
      if (stalled) chk("stall_hold", int'(out_data), int'(held));
      if (done) begin
        seen_done = 1;
        chk("done_after_last", int'(prev_last_hs), 1);
        chk("done_out_valid", int'(out_valid), 0);
        chk("done_busy", int'(busy), 0);
      end else begin
        chk("busy", int'(busy), 1);
      end
      prev_last_hs = 0;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("extra_output", nhs + 1, deg + 1);
        end else begin
          chk("out_data", int'(out_data), int'(expq[0]));
          chk("out_last", int'(out_last), int'(expq.size() == 1));
          prev_last_hs = out_last;
          void'(expq.pop_front());
        end
        nhs++;
        if (nhs == abort_at) return;
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      ncyc++;
      @(posedge clk); #1;
    end
    start = 1'b0; in_valid = 1'b0;
    chk("done_seen", int'(seen_done), 1);
    chk("out_count", nhs, deg + 1);
    chk("write_count", k, deg + 1);
    if (exp_cycles >= 0) chk("job_cycles", ncyc, exp_cycles);
    @(negedge clk);
    chk("done_pulse_len", int'(done), 0);
    chk("idle_busy", int'(busy), 0);
    chk("ram_deg_hold", int'(ram_deg), deg);
    last_deg = deg;
    @(posedge clk); #1;
  endtask

  typedef struct {
    int deg;
    bit rev;
    int dsel;
    bit gaps;
    int rmode;
    int exp_cycles;
  } job_t;

  job_t jobs[6];

  initial begin
    jobs[0] = '{deg: 3,   rev: 1'b0, dsel: 0, gaps: 1'b0, rmode: 0, exp_cycles: 10};
    jobs[1] = '{deg: 756, rev: 1'b1, dsel: 1, gaps: 1'b0, rmode: 0, exp_cycles: 1516};
    jobs[2] = '{deg: 2,   rev: 1'b0, dsel: 1, gaps: 1'b0, rmode: 2, exp_cycles: -1};
    jobs[3] = '{deg: 0,   rev: 1'b1, dsel: 2, gaps: 1'b0, rmode: 0, exp_cycles: 4};
    jobs[4] = '{deg: 5,   rev: 1'b1, dsel: 2, gaps: 1'b1, rmode: 1, exp_cycles: -1};
    jobs[5] = '{deg: 1,   rev: 1'b0, dsel: 2, gaps: 1'b1, rmode: 2, exp_cycles: -1};

    rst_n = 1'b0; start = 1'b0; deg_in = '0; rev = 1'b0;
    in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    for (int j = 0; j < 6; j++)
      run_job(jobs[j].deg, jobs[j].rev, jobs[j].dsel, jobs[j].gaps, jobs[j].rmode, 1'b0,
              jobs[j].exp_cycles, -1);

    // rejected starts leave the block idle and keep the old degree
    for (int j = 0; j < 2; j++) begin
      start = 1'b1; deg_in = (j == 0) ? AW'(757) : AW'(2047); rev = 1'b0;
      @(posedge clk); #1;
      start = 1'b0;
      @(negedge clk);
      chk("rej_err", int'(err), 1);
      chk("rej_in_ready", int'(in_ready), 0);
      chk("rej_busy", int'(busy), 0);
      chk("rej_ram_deg", int'(ram_deg), last_deg);
      @(negedge clk);
      chk("rej_err_pulse", int'(err), 0);
      chk("rej_still_idle", int'(in_ready), 0);
      @(posedge clk); #1;
    end

    // start noise during a job must be ignored
    for (int j = 0; j < 8; j++)
      run_job($urandom_range(0, 40), 1'($urandom % 2), 2, 1'($urandom % 2), 1, 1'b1, -1, -1);

    // reset after 5 of 8 outputs, then a single-coefficient job
    run_job(7, 1'b0, 2, 1'b0, 0, 1'b0, -1, 5);
    @(posedge clk); #1;
    rst_n = 1'b0; start = 1'b0; in_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_vals();
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    run_job(0, 1'b0, 2, 1'b0, 0, 1'b0, 4, -1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
